// File: rtl/imem_responder.sv
// Instruction-memory responder: one fetch in flight, word returned WAIT_CYC cycles after acceptance.
// A response is held until rsp_ready. A new request is taken in IDLE, or in the same cycle a response is taken.
module imem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int WAIT_CYC   = 2
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    input  logic        rsp_ready,
    output logic        stall,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] addr_q, addr_nxt;
    logic        load_rsp;
    logic        accept;
    logic        rd_err;
    logic [31:0] mem [1<<DEPTH_LOG2];

    // Range check on all 32 bits so addresses never alias back onto low words.
    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:DEPTH_LOG2+2] != '0);
    endfunction

    assign req_ready = (state == S_IDLE) || ((state == S_RESP) && rsp_ready);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == S_RESP);
    assign stall     = (state == S_WAIT) || ((state == S_RESP) && !rsp_ready);
    assign rd_err    = addr_bad(addr_nxt);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = addr_q;
        load_rsp  = 1'b0;
        case (state)
            S_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = S_RESP;
                    load_rsp  = 1'b1;
                end
            end
            S_RESP: if (rsp_ready) state_nxt = S_IDLE;
            default: ;
        endcase
        if (accept) begin
            addr_nxt = req_addr;
            if (WAIT_CYC == 0) begin
                state_nxt = S_RESP;
                load_rsp  = 1'b1;
            end else begin
                state_nxt = S_WAIT;
                cnt_nxt   = WAIT_LD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            addr_q <= addr_nxt;
            // Read on RESP entry; a load to the same word this edge is seen only by later fetches.
            if (load_rsp) begin
                rsp_err  <= rd_err;
                rsp_data <= rd_err ? '0 : mem[addr_nxt[DEPTH_LOG2+1:2]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ld_en && !addr_bad(ld_addr))
            mem[ld_addr[DEPTH_LOG2+1:2]] <= ld_data;
    end
endmodule

// File: tb/tb_imem_responder.sv
// Drives a WAIT_CYC=2 and a WAIT_CYC=0 responder with shared stimulus, checked against a fetch-level model.
module tb_imem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        rsp_ready = 1'b0;
    logic        ld_en = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_data = '0;

    logic        rdy [2];
    logic        vld [2];
    logic        err [2];
    logic        stl [2];
    logic [31:0] dat [2];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: per instance, is a fetch outstanding and in which cycle its answer appears.
    int          waits [2] = '{2, 0};
    bit          busy  [2];
    int          due   [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_data [2];
    bit          m_err  [2];
    logic [31:0] mem_m [1024];
    int          cyc = 0;

    always #5 clk = ~clk;

    imem_responder #(.DEPTH_LOG2(10), .WAIT_CYC(2)) u_dut (
        .rst(rst), .clk(clk), .req_valid(req_valid), .req_addr(req_addr), .req_ready(rdy[0]),
        .rsp_valid(vld[0]), .rsp_data(dat[0]), .rsp_err(err[0]), .rsp_ready(rsp_ready),
        .stall(stl[0]), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    imem_responder #(.DEPTH_LOG2(10), .WAIT_CYC(0)) u_dut0 (
        .rst(rst), .clk(clk), .req_valid(req_valid), .req_addr(req_addr), .req_ready(rdy[1]),
        .rsp_valid(vld[1]), .rsp_data(dat[1]), .rsp_err(err[1]), .rsp_ready(rsp_ready),
        .stall(stl[1]), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'h0000_1000);
    endfunction

    // Called just after a negedge with inputs driven: check outputs, advance the model over the next posedge.
    task automatic step();
        bit ev [2];
        bit er [2];
        bit acc, comp;
        #1;
        for (int i = 0; i < 2; i++) begin
            ev[i] = busy[i] && (cyc >= due[i]);
            er[i] = !busy[i] || (ev[i] && rsp_ready);
            check($sformatf("rsp_valid%0d", i), vld[i], ev[i]);
            check($sformatf("req_ready%0d", i), rdy[i], er[i]);
            check($sformatf("stall%0d", i), stl[i], busy[i] && !(ev[i] && rsp_ready));
            if (ev[i]) begin
                check($sformatf("rsp_data%0d", i), dat[i], m_data[i]);
                check($sformatf("rsp_err%0d", i), err[i], m_err[i]);
            end
        end
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            acc  = req_valid && er[i];
            comp = ev[i] && rsp_ready;
            if (comp && !acc) busy[i] = 1'b0;
            if (acc) begin
                busy[i]   = 1'b1;
                m_addr[i] = req_addr;
                due[i]    = cyc + waits[i];
            end
            if (busy[i] && due[i] == cyc) begin
                m_err[i]  = is_bad(m_addr[i]);
                m_data[i] = m_err[i] ? 32'h0 : mem_m[m_addr[i][11:2]];
            end
        end
        if (ld_en && !is_bad(ld_addr)) mem_m[ld_addr[11:2]] = ld_data;
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [31:0] a, input bit rr);
        req_valid = v;
        req_addr  = a;
        rsp_ready = rr;
    endtask

    task automatic drain();
        drive(1'b0, 32'h0, 1'b1);
        ld_en = 1'b0;
        repeat (4) step();
    endtask

    task automatic pulse_reset();
        drive(1'b0, 32'h0, 1'b0);
        ld_en = 1'b0;
        rst   = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_valid%0d", i), vld[i], 1'b0);
            check($sformatf("rst_stall%0d", i), stl[i], 1'b0);
            check($sformatf("rst_data%0d", i), dat[i], 32'h0);
            check($sformatf("rst_err%0d", i), err[i], 1'b0);
            busy[i] = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            busy[i] = 1'b0;
            due[i]  = 0;
        end
        @(negedge clk);
        pulse_reset();
        check("rst_ready0", rdy[0], 1'b1);

        // Preload every word so no fetch ever reads an unwritten location.
        for (int w = 0; w < 1024; w++) begin
            ld_en   = 1'b1;
            ld_addr = w * 4;
            ld_data = (w == 0) ? 32'h0050_0093 : (w == 1) ? 32'h0010_0113 : $urandom;
            step();
        end
        ld_en = 1'b0;

        // Single fetch with two wait states.
        drive(1'b1, 32'h0, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b1);
        check("t1_stall_w1", stl[0], 1'b1);
        step();
        check("t1_stall_w2", stl[0], 1'b1);
        step();
        check("t1_valid", vld[0], 1'b1);
        check("t1_data", dat[0], 32'h0050_0093);
        check("t1_err", err[0], 1'b0);
        drain();

        // Back-to-back on the zero-wait instance.
        drive(1'b1, 32'h0, 1'b1);
        step();
        drive(1'b1, 32'h4, 1'b1);
        check("t2_data_a", dat[1], 32'h0050_0093);
        check("t2_stall_a", stl[1], 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b1);
        check("t2_data_b", dat[1], 32'h0010_0113);
        check("t2_stall_b", stl[1], 1'b0);
        step();
        drain();

        // Backpressure held in RESP, then a new request on the cycle rsp_ready rises.
        drive(1'b1, 32'h4, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0);
        repeat (6) step();
        check("t3_ready_held", rdy[0], 1'b0);
        check("t3_stall_held", stl[0], 1'b1);
        check("t3_data_held", dat[0], 32'h0010_0113);
        drive(1'b1, 32'h0, 1'b1);
        step();
        check("t3_reaccept", stl[0], 1'b1);
        drain();

        // Error addresses and a dropped out-of-range load.
        drive(1'b1, 32'h2, 1'b1);
        step();
        check("t4_mis_err", err[1], 1'b1);
        check("t4_mis_data", dat[1], 32'h0);
        drain();
        drive(1'b1, 32'h1000, 1'b1);
        ld_en = 1'b1; ld_addr = 32'h1000; ld_data = 32'h1234_5678;
        step();
        ld_en = 1'b0;
        check("t4_oor_err", err[1], 1'b1);
        check("t4_oor_data", dat[1], 32'h0);
        drain();
        drive(1'b1, 32'h0, 1'b1);
        step();
        check("t4_word0", dat[1], 32'h0050_0093);
        drain();

        // Load collides with the RESP-entry read of the WAIT_CYC=2 instance.
        drive(1'b1, 32'h4, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b1);
        step();
        ld_en = 1'b1; ld_addr = 32'h4; ld_data = 32'hDEAD_BEEF;
        step();
        ld_en = 1'b0;
        check("t5_old_word", dat[0], 32'h0010_0113);
        drain();
        drive(1'b1, 32'h4, 1'b1);
        step();
        check("t5_new_word", dat[1], 32'hDEAD_BEEF);
        drain();

        // Reset while waiting drops the fetch; memory survives.
        drive(1'b1, 32'h0, 1'b1);
        step();
        check("t6_in_wait", stl[0], 1'b1);
        pulse_reset();
        drain();
        drive(1'b1, 32'h0, 1'b1);
        step();
        check("t6_mem_kept", dat[1], 32'h0050_0093);
        drain();

        // Random traffic: mixed valid/ready, good and bad addresses, concurrent loads.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = ($urandom_range(0, 1023) * 4) | $urandom_range(1, 3);
                2:       a = 32'h1000 + $urandom_range(0, 15) * 4;
                default: a = $urandom_range(0, 1023) * 4;
            endcase
            drive($urandom_range(0, 1) == 1, a, $urandom_range(0, 3) != 0);
            ld_en   = ($urandom_range(0, 9) == 0);
            ld_addr = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 1023) * 4;
            ld_data = $urandom;
            step();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
